// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// reset PC and the fetch state encoding.
package instr_fetch_unit_pkg;

    localparam int unsigned DEF_ADDR_W   = 24;
    localparam int unsigned DEF_INS_W    = 24;
    localparam int unsigned DEF_IRAM_LAT = 1;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_PC_STEP  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: synchronous reset, load has priority over
// increment, increment wraps modulo 2^ADDR_W. pc_next is exposed so the
// owner can register the address that the PC is about to take.
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    // Next PC: redirect beats increment, otherwise hold
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = target;
        end else if (inc) begin
            pc_next = pc + ADDR_W'(PC_STEP);
        end
    end

    // PC storage
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= ADDR_W'(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues IRAM reads from the PC, waits IRAM_LAT
// cycles, captures the word and holds it for decode on a valid/ready
// handshake. pc_load redirects the stream, halt returns to IDLE after
// the in-flight instruction has been delivered.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned INS_W    = DEF_INS_W,
    parameter int unsigned IRAM_LAT = DEF_IRAM_LAT,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INS_W-1:0]  mem_ins,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic              busy
);

    localparam int unsigned LAT_W = (IRAM_LAT < 1) ? 1 : $clog2(IRAM_LAT + 1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [LAT_W-1:0]  lat_cnt;
    logic [LAT_W-1:0]  lat_cnt_nxt;
    logic              halt_pend;
    logic              halt_pend_nxt;
    logic              lat_done;
    logic              redirect;
    logic              pc_inc;
    logic              mem_read_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [INS_W-1:0]  ins_out_nxt;
    logic [ADDR_W-1:0] ins_pc_nxt;
    logic              ins_valid_nxt;
    logic              busy_nxt;

    // Last WAIT cycle: the IRAM word is on mem_ins now
    assign lat_done = (state == ST_WAIT) && (lat_cnt == LAT_W'(1));
    // Redirect only aborts work in the active states; in IDLE it just moves the PC
    assign redirect = pc_load && (state != ST_IDLE);
    // Advance the PC as the instruction is captured, unless it is being redirected
    assign pc_inc   = lat_done && !pc_load;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .load    (pc_load),
        .target  (pc_target),
        .inc     (pc_inc),
        .pc      (pc),
        .pc_next (pc_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!pc_load && start) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pc_load) begin
                    state_nxt = halt_pend ? ST_IDLE : ST_ISSUE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pc_load) begin
                    state_nxt = halt_pend ? ST_IDLE : ST_ISSUE;
                end else if (lat_done) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // pc_load with ins_ready: the held word is consumed, then the redirect applies
                if (pc_load) begin
                    state_nxt = halt_pend ? ST_IDLE : ST_ISSUE;
                end else if (ins_ready) begin
                    state_nxt = (halt_pend || halt) ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath state
    always_comb begin
        // mem_read/mem_addr are aligned with the ISSUE state, so they are
        // derived from the state being entered and the PC being loaded
        mem_read_nxt  = (state_nxt == ST_ISSUE);
        mem_addr_nxt  = (state_nxt == ST_ISSUE) ? pc_next : mem_addr;
        busy_nxt      = (state_nxt != ST_IDLE);
        ins_out_nxt   = ins_out;
        ins_pc_nxt    = ins_pc;
        ins_valid_nxt = ins_valid;
        lat_cnt_nxt   = lat_cnt;
        halt_pend_nxt = halt_pend;

        if ((state != ST_IDLE) && halt) begin
            halt_pend_nxt = 1'b1;
        end
        if (state_nxt == ST_IDLE) begin
            halt_pend_nxt = 1'b0;
        end

        if (redirect) begin
            ins_valid_nxt = 1'b0;
            lat_cnt_nxt   = '0;
        end else begin
            case (state)
                ST_ISSUE: lat_cnt_nxt = LAT_W'(IRAM_LAT);
                ST_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt_nxt = lat_cnt - LAT_W'(1);
                    end
                    if (lat_done) begin
                        ins_out_nxt   = mem_ins;
                        ins_pc_nxt    = pc;
                        ins_valid_nxt = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (ins_ready) begin
                        ins_valid_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read  <= 1'b0;
            mem_addr  <= ADDR_W'(RESET_PC);
            ins_out   <= '0;
            ins_pc    <= '0;
            ins_valid <= 1'b0;
            busy      <= 1'b0;
            lat_cnt   <= '0;
            halt_pend <= 1'b0;
        end else begin
            mem_read  <= mem_read_nxt;
            mem_addr  <= mem_addr_nxt;
            ins_out   <= ins_out_nxt;
            ins_pc    <= ins_pc_nxt;
            ins_valid <= ins_valid_nxt;
            busy      <= busy_nxt;
            lat_cnt   <= lat_cnt_nxt;
            halt_pend <= halt_pend_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle-by-cycle vector table on an
// IRAM_LAT=1 instance, plus a latency/throughput sequence on an IRAM_LAT=3 one.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt;
    logic        pc_load;
    logic [23:0] pc_target;
    logic        ins_ready;

    logic        mem_read,  mem_read3;
    logic [23:0] mem_addr,  mem_addr3;
    logic [23:0] mem_ins,   mem_ins3;
    logic [23:0] ins_out,   ins_out3;
    logic [23:0] ins_pc,    ins_pc3;
    logic        ins_valid, ins_valid3;
    logic        busy,      busy3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit u_dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .pc_load(pc_load), .pc_target(pc_target),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_ins(mem_ins),
        .ins_out(ins_out), .ins_pc(ins_pc), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .busy(busy)
    );

    instr_fetch_unit #(.IRAM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .pc_load(pc_load), .pc_target(pc_target),
        .mem_read(mem_read3), .mem_addr(mem_addr3), .mem_ins(mem_ins3),
        .ins_out(ins_out3), .ins_pc(ins_pc3), .ins_valid(ins_valid3),
        .ins_ready(ins_ready), .busy(busy3)
    );

    // IRAM contents: word at address a is A00000 ^ a (mem[0..3] = A00000..A00003)
    function automatic logic [23:0] iram_word(input logic [23:0] a);
        return 24'hA00000 ^ a;
    endfunction

    // IRAM models: data valid exactly LAT cycles after the read, zero otherwise
    logic [23:0] m1 = '0;
    logic [23:0] m3 [3] = '{24'h0, 24'h0, 24'h0};
    always @(posedge clk) m1 <= mem_read ? iram_word(mem_addr) : 24'h0;
    always @(posedge clk) begin
        m3[0] <= mem_read3 ? iram_word(mem_addr3) : 24'h0;
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign mem_ins  = m1;
    assign mem_ins3 = m3[2];

    typedef struct {
        logic        rst, st, hl, ld;
        logic [23:0] tgt;
        logic        rdy;
        logic        e_mr;
        logic [23:0] e_addr;
        logic        e_val;
        logic [23:0] e_pc;
        logic [23:0] e_out;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mkv(input logic rst, st, hl, ld, input logic [23:0] tgt,
                                 input logic rdy, input logic e_mr, input logic [23:0] e_addr,
                                 input logic e_val, input logic [23:0] e_pc,
                                 input logic [23:0] e_out, input logic e_busy);
        vec_t v;
        v.rst = rst; v.st = st; v.hl = hl; v.ld = ld; v.tgt = tgt; v.rdy = rdy;
        v.e_mr = e_mr; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
        v.e_out = e_out; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [45];

    initial begin
        // rst st hl ld target    rdy | mr addr       val pc         out        busy
        tbl[0]  = mkv(0,1,0,0,24'h0,     1, 1,24'h000000,0,24'h0,     24'h0,     1);
        tbl[1]  = mkv(0,0,0,0,24'h0,     1, 0,24'h000000,0,24'h0,     24'h0,     1);
        tbl[2]  = mkv(0,0,0,0,24'h0,     1, 0,24'h000000,1,24'h000000,24'hA00000,1);
        tbl[3]  = mkv(0,0,0,0,24'h0,     1, 1,24'h000001,0,24'h0,     24'h0,     1);
        tbl[4]  = mkv(0,0,0,0,24'h0,     1, 0,24'h000001,0,24'h0,     24'h0,     1);
        tbl[5]  = mkv(0,0,0,0,24'h0,     1, 0,24'h000001,1,24'h000001,24'hA00001,1);
        tbl[6]  = mkv(0,0,0,0,24'h0,     1, 1,24'h000002,0,24'h0,     24'h0,     1);
        tbl[7]  = mkv(0,0,0,0,24'h0,     1, 0,24'h000002,0,24'h0,     24'h0,     1);
        tbl[8]  = mkv(0,0,0,0,24'h0,     1, 0,24'h000002,1,24'h000002,24'hA00002,1);
        // decode stalls for 5 cycles while holding pc=2
        tbl[9]  = mkv(0,0,0,0,24'h0,     0, 0,24'h000002,1,24'h000002,24'hA00002,1);
        tbl[10] = mkv(0,0,0,0,24'h0,     0, 0,24'h000002,1,24'h000002,24'hA00002,1);
        tbl[11] = mkv(0,0,0,0,24'h0,     0, 0,24'h000002,1,24'h000002,24'hA00002,1);
        tbl[12] = mkv(0,0,0,0,24'h0,     0, 0,24'h000002,1,24'h000002,24'hA00002,1);
        tbl[13] = mkv(0,0,0,0,24'h0,     0, 0,24'h000002,1,24'h000002,24'hA00002,1);
        tbl[14] = mkv(0,0,0,0,24'h0,     1, 1,24'h000003,0,24'h0,     24'h0,     1);
        tbl[15] = mkv(0,0,0,0,24'h0,     1, 0,24'h000003,0,24'h0,     24'h0,     1);
        tbl[16] = mkv(0,0,0,0,24'h0,     1, 0,24'h000003,1,24'h000003,24'hA00003,1);
        tbl[17] = mkv(0,0,0,0,24'h0,     1, 1,24'h000004,0,24'h0,     24'h0,     1);
        tbl[18] = mkv(0,0,0,0,24'h0,     1, 0,24'h000004,0,24'h0,     24'h0,     1);
        // redirect to 12 during WAIT: fetch of 4 is dropped
        tbl[19] = mkv(0,0,0,1,24'h00000C,1, 1,24'h00000C,0,24'h0,     24'h0,     1);
        tbl[20] = mkv(0,0,0,0,24'h0,     1, 0,24'h00000C,0,24'h0,     24'h0,     1);
        tbl[21] = mkv(0,0,0,0,24'h0,     1, 0,24'h00000C,1,24'h00000C,24'hA0000C,1);
        // redirect with ready in HOLD to FFFFFF, then wrap to 0
        tbl[22] = mkv(0,0,0,1,24'hFFFFFF,1, 1,24'hFFFFFF,0,24'h0,     24'h0,     1);
        tbl[23] = mkv(0,0,0,0,24'h0,     1, 0,24'hFFFFFF,0,24'h0,     24'h0,     1);
        tbl[24] = mkv(0,0,0,0,24'h0,     1, 0,24'hFFFFFF,1,24'hFFFFFF,24'h5FFFFF,1);
        tbl[25] = mkv(0,0,0,0,24'h0,     1, 1,24'h000000,0,24'h0,     24'h0,     1);
        tbl[26] = mkv(0,0,0,0,24'h0,     1, 0,24'h000000,0,24'h0,     24'h0,     1);
        tbl[27] = mkv(0,0,0,0,24'h0,     1, 0,24'h000000,1,24'h000000,24'hA00000,1);
        // jump to 5, halt during WAIT, instruction 5 still delivered
        tbl[28] = mkv(0,0,0,1,24'h000005,1, 1,24'h000005,0,24'h0,     24'h0,     1);
        tbl[29] = mkv(0,0,0,0,24'h0,     1, 0,24'h000005,0,24'h0,     24'h0,     1);
        tbl[30] = mkv(0,0,1,0,24'h0,     1, 0,24'h000005,1,24'h000005,24'hA00005,1);
        tbl[31] = mkv(0,0,0,0,24'h0,     1, 0,24'h000005,0,24'h0,     24'h0,     0);
        tbl[32] = mkv(0,0,0,0,24'h0,     1, 0,24'h000005,0,24'h0,     24'h0,     0);
        tbl[33] = mkv(0,1,0,0,24'h0,     1, 1,24'h000006,0,24'h0,     24'h0,     1);
        tbl[34] = mkv(0,0,0,0,24'h0,     1, 0,24'h000006,0,24'h0,     24'h0,     1);
        tbl[35] = mkv(0,0,0,0,24'h0,     1, 0,24'h000006,1,24'h000006,24'hA00006,1);
        // halt raised in HOLD together with ready
        tbl[36] = mkv(0,0,1,0,24'h0,     1, 0,24'h000006,0,24'h0,     24'h0,     0);
        // pc_load beats start in IDLE
        tbl[37] = mkv(0,1,0,1,24'h000009,1, 0,24'h000006,0,24'h0,     24'h0,     0);
        tbl[38] = mkv(0,1,0,0,24'h0,     1, 1,24'h000009,0,24'h0,     24'h0,     1);
        tbl[39] = mkv(0,0,0,0,24'h0,     1, 0,24'h000009,0,24'h0,     24'h0,     1);
        tbl[40] = mkv(0,0,0,0,24'h0,     0, 0,24'h000009,1,24'h000009,24'hA00009,1);
        // reset while holding an instruction
        tbl[41] = mkv(1,0,0,0,24'h0,     0, 0,24'h000000,0,24'h000000,24'h000000,0);
        tbl[42] = mkv(0,1,0,0,24'h0,     1, 1,24'h000000,0,24'h0,     24'h0,     1);
        tbl[43] = mkv(0,0,0,0,24'h0,     1, 0,24'h000000,0,24'h0,     24'h0,     1);
        tbl[44] = mkv(0,0,0,0,24'h0,     1, 0,24'h000000,1,24'h000000,24'hA00000,1);

        reset = 1'b1; start = 1'b0; halt = 1'b0; pc_load = 1'b0;
        pc_target = '0; ins_ready = 1'b1;
        tick();
        tick();
        check("rst_mem_read",  0, 24'(mem_read),  24'h0);
        check("rst_mem_addr",  0, mem_addr,       24'h0);
        check("rst_ins_valid", 0, 24'(ins_valid), 24'h0);
        check("rst_ins_pc",    0, ins_pc,         24'h0);
        check("rst_ins_out",   0, ins_out,        24'h0);
        check("rst_busy",      0, 24'(busy),      24'h0);
        reset = 1'b0;

        for (int i = 0; i < 45; i++) begin
            reset     = tbl[i].rst;
            start     = tbl[i].st;
            halt      = tbl[i].hl;
            pc_load   = tbl[i].ld;
            pc_target = tbl[i].tgt;
            ins_ready = tbl[i].rdy;
            tick();
            check("mem_read",  i, 24'(mem_read),  24'(tbl[i].e_mr));
            check("mem_addr",  i, mem_addr,       tbl[i].e_addr);
            check("ins_valid", i, 24'(ins_valid), 24'(tbl[i].e_val));
            check("busy",      i, 24'(busy),      24'(tbl[i].e_busy));
            if (tbl[i].e_val || tbl[i].rst) begin
                check("ins_pc",  i, ins_pc,  tbl[i].e_pc);
                check("ins_out", i, ins_out, tbl[i].e_out);
            end
        end

        // IRAM_LAT=3 instance: latency from ISSUE and issue-to-issue throughput
        begin
            int n;
            reset = 1'b1; start = 1'b0; halt = 1'b0; pc_load = 1'b0; ins_ready = 1'b1;
            tick();
            reset = 1'b0;
            check("l3_rst_busy", 0, 24'(busy3), 24'h0);
            start = 1'b1;
            tick();
            start = 1'b0;
            check("l3_issue_read", 0, 24'(mem_read3), 24'h1);
            check("l3_issue_addr", 0, mem_addr3,      24'h0);
            n = 0;
            while (!ins_valid3 && n < 20) begin
                tick();
                n++;
            end
            check("l3_first_latency", 0, 24'(n), 24'd4);
            check("l3_first_pc",      0, ins_pc3,  24'h000000);
            check("l3_first_out",     0, ins_out3, 24'hA00000);
            tick();
            n = 1;
            check("l3_valid_drop", 0, 24'(ins_valid3), 24'h0);
            while (!ins_valid3 && n < 20) begin
                tick();
                n++;
            end
            check("l3_period",     0, 24'(n), 24'd5);
            check("l3_second_pc",  0, ins_pc3,  24'h000001);
            check("l3_second_out", 0, ins_out3, 24'hA00001);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

endmodule
